// File: rtl/prf_wb_arbiter.sv
// Writeback arbiter: N_REQ one-entry holding buffers share the single PRF write port.
// Round-robin grant per cycle; registered write/broadcast on wb_*.
module prf_wb_arbiter #(
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned XLEN   = 32,
   parameter int unsigned PREG_W = 6
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      squash,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*PREG_W-1:0]   req_tag,
   input  logic [N_REQ*XLEN-1:0]     req_data,
   output logic [N_REQ-1:0]          req_ready,
   output logic                      wb_en,
   output logic [PREG_W-1:0]         wb_tag,
   output logic [XLEN-1:0]           wb_data,
   output logic [N_REQ-1:0]          wb_src
);

   localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]  buf_v;
   logic [PREG_W-1:0] buf_tag  [N_REQ];
   logic [XLEN-1:0]   buf_data [N_REQ];
   logic [PTR_W-1:0]  rr_ptr;
   logic [PTR_W-1:0]  rr_next;
   logic [N_REQ-1:0]  grant;
   logic [PTR_W-1:0]  grant_idx;
   logic              grant_any;
   logic [N_REQ-1:0]  accept;

   // Rotating priority scan starting at rr_ptr; first full buffer wins.
   always_comb begin : arb
      logic [PTR_W:0] scan;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      scan      = '0;
      for (int unsigned o = 0; o < N_REQ; o++) begin
         scan = {1'b0, rr_ptr} + (PTR_W+1)'(o);
         if (scan >= (PTR_W+1)'(N_REQ)) begin
            scan = scan - (PTR_W+1)'(N_REQ);
         end
         if (!grant_any && buf_v[PTR_W'(scan)]) begin
            grant_any                = 1'b1;
            grant_idx                = PTR_W'(scan);
            grant[PTR_W'(scan)]      = 1'b1;
         end
      end
   end

   assign rr_next   = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
   // A buffer being drained this cycle may be refilled in the same cycle.
   assign req_ready = (~buf_v | grant) & {N_REQ{~squash & ~reset}};
   assign accept    = req_valid & req_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         buf_v   <= '0;
         rr_ptr  <= '0;
         wb_en   <= 1'b0;
         wb_tag  <= '0;
         wb_data <= '0;
         wb_src  <= '0;
         for (int unsigned i = 0; i < N_REQ; i++) begin
            buf_tag[i]  <= '0;
            buf_data[i] <= '0;
         end
      end else if (squash) begin
         // Flush: drop buffers and this cycle's grant; keep rr_ptr and last tag/data.
         buf_v  <= '0;
         wb_en  <= 1'b0;
         wb_src <= '0;
      end else begin
         wb_en  <= grant_any;
         wb_src <= grant;
         if (grant_any) begin
            wb_tag  <= buf_tag[grant_idx];
            wb_data <= buf_data[grant_idx];
            rr_ptr  <= rr_next;
         end
         for (int unsigned i = 0; i < N_REQ; i++) begin
            // Tag 0 is the hardwired zero register: accepted but never buffered.
            if (accept[i] && (req_tag[i*PREG_W +: PREG_W] != '0)) begin
               buf_v[i]    <= 1'b1;
               buf_tag[i]  <= req_tag[i*PREG_W +: PREG_W];
               buf_data[i] <= req_data[i*XLEN +: XLEN];
            end else if (grant[i]) begin
               buf_v[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_prf_wb_arbiter.sv
// Directed bench for prf_wb_arbiter: expected writes queued at drive time, popped on wb_en.
module tb_prf_wb_arbiter;

   localparam int unsigned N_REQ  = 4;
   localparam int unsigned XLEN   = 32;
   localparam int unsigned PREG_W = 6;

   logic                    clock;
   logic                    reset;
   logic                    squash;
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*PREG_W-1:0] req_tag;
   logic [N_REQ*XLEN-1:0]   req_data;
   logic [N_REQ-1:0]        req_ready;
   logic                    wb_en;
   logic [PREG_W-1:0]       wb_tag;
   logic [XLEN-1:0]         wb_data;
   logic [N_REQ-1:0]        wb_src;

   typedef struct packed {
      logic [PREG_W-1:0] tag;
      logic [XLEN-1:0]   data;
      logic [N_REQ-1:0]  src;
   } wb_exp_t;

   wb_exp_t exp_q[$];
   int      n_assert = 0;
   int      n_fail   = 0;

   prf_wb_arbiter #(.N_REQ(N_REQ), .XLEN(XLEN), .PREG_W(PREG_W)) dut (
      .clock     (clock),
      .reset     (reset),
      .squash    (squash),
      .req_valid (req_valid),
      .req_tag   (req_tag),
      .req_data  (req_data),
      .req_ready (req_ready),
      .wb_en     (wb_en),
      .wb_tag    (wb_tag),
      .wb_data   (wb_data),
      .wb_src    (wb_src)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle, sample 1 time unit after the edge and score any write.
   task automatic tick();
      wb_exp_t e;
      @(posedge clock);
      #1;
      if (wb_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_wb", 64'(exp_q.size()), 64'd1);
         end else begin
            e = exp_q.pop_front();
            chk("sb_wb_tag", 64'(wb_tag), 64'(e.tag));
            chk("sb_wb_data", 64'(wb_data), 64'(e.data));
            chk("sb_wb_src", 64'(wb_src), 64'(e.src));
         end
      end else begin
         chk("idle_wb_src", 64'(wb_src), 64'd0);
      end
   endtask

   task automatic set_req(input int i, input logic v, input logic [PREG_W-1:0] t,
                          input logic [XLEN-1:0] d);
      req_valid[i]                = v;
      req_tag[i*PREG_W +: PREG_W] = t;
      req_data[i*XLEN +: XLEN]    = d;
   endtask

   task automatic push(input int i, input logic [PREG_W-1:0] t, input logic [XLEN-1:0] d);
      wb_exp_t e;
      e.tag  = t;
      e.data = d;
      e.src  = N_REQ'(1) << i;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      logic [N_REQ-1:0] exp_rdy;

      // 1 Reset with all requests asserted
      reset     = 1'b1;
      squash    = 1'b0;
      req_valid = '1;
      req_tag   = '0;
      req_data  = '0;
      for (int i = 0; i < int'(N_REQ); i++) set_req(i, 1'b1, PREG_W'(i + 1), $urandom);
      tick();
      tick();
      reset     = 1'b0;
      req_valid = '0;
      #1;
      chk("rst_wb_en", 64'(wb_en), 64'd0);
      chk("rst_wb_tag", 64'(wb_tag), 64'd0);
      chk("rst_wb_data", 64'(wb_data), 64'd0);
      chk("rst_wb_src", 64'(wb_src), 64'd0);
      chk("rst_ready", 64'(req_ready), 64'hF);
      tick();
      chk("rst_no_write", 64'(wb_en), 64'd0);

      // 2 Single request, write appears two edges later for one cycle
      set_req(0, 1'b1, 6'd5, 32'hDEAD_BEEF);
      push(0, 6'd5, 32'hDEAD_BEEF);
      tick();
      chk("t2_en_t1", 64'(wb_en), 64'd0);
      set_req(0, 1'b0, 6'd0, 32'd0);
      tick();
      chk("t2_en_t2", 64'(wb_en), 64'd1);
      tick();
      chk("t2_en_t3", 64'(wb_en), 64'd0);
      chk("t2_tag_hold", 64'(wb_tag), 64'd5);
      chk("t2_data_hold", 64'(wb_data), 64'hDEAD_BEEF);

      // 3 Round-robin with all requesters streaming
      do_reset();
      for (int c = 0; c < 8; c++) begin
         exp_rdy = (c == 0) ? N_REQ'('hF) : N_REQ'(1) << ((c - 1) % int'(N_REQ));
         for (int i = 0; i < int'(N_REQ); i++)
            set_req(i, 1'b1, PREG_W'(i + 1), 32'hA000_0000 | (32'(i) << 8) | 32'(c));
         #1;
         chk("t3_ready", 64'(req_ready), 64'(exp_rdy));
         for (int i = 0; i < int'(N_REQ); i++)
            if (exp_rdy[i]) push(i, PREG_W'(i + 1), 32'hA000_0000 | (32'(i) << 8) | 32'(c));
         tick();
         chk("t3_en", 64'(wb_en), (c == 0) ? 64'd0 : 64'd1);
      end
      for (int i = 0; i < int'(N_REQ); i++) set_req(i, 1'b0, '0, '0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("t3_drain_en", 64'(wb_en), 64'd1);
      end
      tick();
      chk("t3_idle_en", 64'(wb_en), 64'd0);

      // 4 Backpressure on requester 2 while 0 and 1 drain first
      set_req(0, 1'b1, 6'h0A, 32'h100);
      set_req(1, 1'b1, 6'h0B, 32'h101);
      set_req(2, 1'b1, 6'h21, 32'h201);
      push(0, 6'h0A, 32'h100);
      push(1, 6'h0B, 32'h101);
      push(2, 6'h21, 32'h201);
      tick();
      chk("t4_en_c0", 64'(wb_en), 64'd0);
      set_req(0, 1'b0, '0, '0);
      set_req(1, 1'b0, '0, '0);
      set_req(2, 1'b1, 6'h22, 32'h202);
      #1;
      chk("t4_rdy2_c1", 64'(req_ready[2]), 64'd0);
      tick();
      #1;
      chk("t4_rdy2_c2", 64'(req_ready[2]), 64'd0);
      tick();
      #1;
      chk("t4_rdy2_c3", 64'(req_ready[2]), 64'd1);
      push(2, 6'h22, 32'h202);
      tick();
      chk("t4_first_en", 64'(wb_en), 64'd1);
      chk("t4_first_src", 64'(wb_src), 64'b0100);
      set_req(2, 1'b0, '0, '0);
      tick();
      chk("t4_second_en", 64'(wb_en), 64'd1);
      chk("t4_second_src", 64'(wb_src), 64'b0100);
      tick();
      chk("t4_idle_en", 64'(wb_en), 64'd0);

      // 5 Tag 0 is dropped, then a normal write from the same requester
      set_req(1, 1'b1, 6'd0, 32'd7);
      #1;
      chk("t5_rdy1", 64'(req_ready[1]), 64'd1);
      tick();
      set_req(1, 1'b0, '0, '0);
      tick();
      chk("t5_no_wb_a", 64'(wb_en), 64'd0);
      tick();
      chk("t5_no_wb_b", 64'(wb_en), 64'd0);
      set_req(1, 1'b1, 6'd9, 32'h99);
      push(1, 6'd9, 32'h99);
      tick();
      set_req(1, 1'b0, '0, '0);
      tick();
      chk("t5_tag9_en", 64'(wb_en), 64'd1);
      chk("t5_tag9_src", 64'(wb_src), 64'b0010);
      tick();

      // 6 Squash discards buffers 0 and 3; rr_ptr (now 2) survives
      set_req(0, 1'b1, 6'h11, 32'h111);
      set_req(3, 1'b1, 6'h13, 32'h113);
      tick();
      set_req(0, 1'b0, '0, '0);
      set_req(3, 1'b0, '0, '0);
      squash = 1'b1;
      #1;
      chk("t6_ready_squash", 64'(req_ready), 64'd0);
      tick();
      chk("t6_en_after", 64'(wb_en), 64'd0);
      squash = 1'b0;
      #1;
      chk("t6_ready_after", 64'(req_ready), 64'hF);
      tick();
      chk("t6_en_flushed", 64'(wb_en), 64'd0);
      set_req(0, 1'b1, 6'h30, 32'h300);
      set_req(3, 1'b1, 6'h33, 32'h333);
      push(3, 6'h33, 32'h333);
      push(0, 6'h30, 32'h300);
      tick();
      set_req(0, 1'b0, '0, '0);
      set_req(3, 1'b0, '0, '0);
      tick();
      chk("t6_rr_first_src", 64'(wb_src), 64'b1000);
      tick();
      chk("t6_rr_second_src", 64'(wb_src), 64'b0001);
      tick();

      for (int k = 0; k < 10 && exp_q.size() > 0; k++) tick();
      chk("sb_drained", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
